// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl_if
// Purpose  : Divide-ratio configuration handshake between the control
//            registers (master) and the tick controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  // Control-register side: offers a ratio, observes accept/reject.
  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  // Controller side: consumes the ratio, reports ready and rejection.
  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Programmable tick generator. Emits one-cycle ticks every cur_div
//            cycles, continuously or for a fixed burst, and accepts new divide
//            ratios that only take effect on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  wire logic         clk_in,
  input  wire logic         reset_n,
  clk_div_ctrl_if.slave     cfg,
  input  wire logic         start,
  input  wire logic         stop,
  input  wire logic [BURST_W-1:0] burst_len,
  output logic              tick,
  output logic              busy,
  output logic              done,
  output logic [BURST_W-1:0] tick_count,
  output logic [CNT_W-1:0]  cur_div
);

  localparam logic [CNT_W-1:0]   c_default_div = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0]   c_min_div     = CNT_W'(2);
  localparam logic [CNT_W-1:0]   c_cnt_one     = CNT_W'(1);
  localparam logic [BURST_W-1:0] c_burst_one   = BURST_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [CNT_W-1:0]   cur_div_q, cur_div_d;
  logic               pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] tick_count_q, tick_count_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic w_xfer;
  logic w_wrap;
  logic w_div_ok;

  assign w_xfer   = cfg.cfg_valid && cfg_ready_q;
  assign w_wrap   = (counter_q == (cur_div_q - c_cnt_one));
  assign w_div_ok = (cfg.cfg_div >= c_min_div);

  // Next-state and registered-output computation for the IDLE/RUN sequencer.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    cur_div_d    = cur_div_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    burst_d      = burst_q;
    tick_count_d = tick_count_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        counter_d = '0;
        // No period is running, so a good ratio can take effect at once.
        if (w_xfer) begin
          if (w_div_ok) cur_div_d = cfg.cfg_div;
          else          cfg_err_d = 1'b1;
        end
        // stop has priority over a simultaneous start.
        if (start && !stop) begin
          state_d      = S_RUN;
          tick_count_d = '0;
          burst_d      = burst_len;
        end
      end

      S_RUN: begin
        // Good ratios wait for the next boundary so the current period
        // always completes at its original length.
        if (w_xfer) begin
          if (w_div_ok) begin
            pend_valid_d = 1'b1;
            pend_div_d   = cfg.cfg_div;
          end else begin
            cfg_err_d = 1'b1;
          end
        end

        if (stop) begin
          state_d   = S_IDLE;
          counter_d = '0;
        end else if (w_wrap) begin
          counter_d    = '0;
          tick_d       = 1'b1;
          tick_count_d = tick_count_q + c_burst_one;
          // Only a ratio pending before this edge switches here; one accepted
          // on this very edge waits for the following wrap.
          if (pend_valid_q) begin
            cur_div_d    = pend_div_q;
            pend_valid_d = 1'b0;
          end
          if ((burst_q != '0) && (tick_count_d == burst_q)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          counter_d = counter_q + c_cnt_one;
        end

        // Never carry a pending ratio into IDLE: apply it on the exit edge.
        if ((state_d == S_IDLE) && pend_valid_d) begin
          cur_div_d    = pend_div_d;
          pend_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d == S_RUN);
    cfg_ready_d = (state_d == S_IDLE) || !pend_valid_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      cur_div_q    <= c_default_div;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      burst_q      <= '0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      cur_div_q    <= cur_div_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      burst_q      <= burst_d;
      tick_count_q <= tick_count_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign tick          = tick_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign tick_count    = tick_count_q;
  assign cur_div       = cur_div_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Scoreboard bench for clk_div_ctrl. Stimulus pushes expected
//            tick/err events; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] burst_len = '0;
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] tick_count;
  logic [15:0] cur_div;

  clk_div_ctrl_if #(.CNT_W(16)) cfg_if ();

  clk_div_ctrl #(
    .CNT_W(16), .BURST_W(16), .DEFAULT_DIV(4)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .cfg(cfg_if),
    .start(start), .stop(stop), .burst_len(burst_len),
    .tick(tick), .busy(busy), .done(done),
    .tick_count(tick_count), .cur_div(cur_div)
  );

  always #5 clk_in = ~clk_in;

  int edge_n = 0;
  always @(posedge clk_in) edge_n <= edge_n + 1;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        done;
    logic        busy;
    logic [15:0] div;
  } exp_t;

  exp_t tq[$];
  int   eq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic push_tick(input int cyc, input int cnt, input bit dn, input bit bz, input int dv);
    exp_t e;
    e.cyc = cyc; e.cnt = 16'(cnt); e.done = dn; e.busy = bz; e.div = 16'(dv);
    tq.push_back(e);
  endtask

  // Monitor: every tick/done or cfg_err the DUT presents consumes one expectation.
  always @(negedge clk_in) begin
    if (tick || done) begin
      if (tq.size() == 0) begin
        chk("unexpected_tick", 32'(edge_n), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = tq.pop_front();
        chk("tick_cycle", 32'(edge_n), 32'(e.cyc));
        chk("tick_level", {31'd0, tick}, 32'd1);
        chk("tick_count", {16'd0, tick_count}, {16'd0, e.cnt});
        chk("tick_done", {31'd0, done}, {31'd0, e.done});
        chk("tick_busy", {31'd0, busy}, {31'd0, e.busy});
        chk("tick_div", {16'd0, cur_div}, {16'd0, e.div});
      end
    end
    if (cfg_if.cfg_err) begin
      if (eq.size() == 0) chk("unexpected_err", 32'(edge_n), 32'hFFFF_FFFF);
      else                chk("err_cycle", 32'(edge_n), 32'(eq.pop_front()));
    end
  end

  task automatic wait_until(input int n);
    while (edge_n < n) @(negedge clk_in);
  endtask

  // Offer one ratio for a single cycle (caller ensures cfg_ready is high).
  task automatic offer(input int dv);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'(dv);
    @(negedge clk_in);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_start(input int bl, output int e0);
    e0        = edge_n + 1;
    start     = 1'b1;
    burst_len = 16'(bl);
    @(negedge clk_in);
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;

    // Reset values.
    repeat (3) @(negedge clk_in);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, cfg_if.cfg_err}, 32'd0);
    chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("rst_count", {16'd0, tick_count}, 32'd0);
    chk("rst_div", {16'd0, cur_div}, 32'd4);
    reset_n = 1'b1;
    @(negedge clk_in);

    // Continuous run at default ratio 4.
    do_start(0, e0);
    for (int k = 1; k <= 4; k++) push_tick(e0 + 4 * k, k, 1'b0, 1'b1, 4);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_count0", {16'd0, tick_count}, 32'd0);
    wait_until(e0 + 17);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    chk("stop1_busy", {31'd0, busy}, 32'd0);
    chk("stop1_count", {16'd0, tick_count}, 32'd4);

    // Ratio 10 in IDLE, then a 3-tick burst.
    offer(10);
    chk("idle_div10", {16'd0, cur_div}, 32'd10);
    do_start(3, e0);
    push_tick(e0 + 10, 1, 1'b0, 1'b1, 10);
    push_tick(e0 + 20, 2, 1'b0, 1'b1, 10);
    push_tick(e0 + 30, 3, 1'b1, 1'b0, 10);
    wait_until(e0 + 34);
    chk("burst_busy", {31'd0, busy}, 32'd0);
    chk("burst_count", {16'd0, tick_count}, 32'd3);
    chk("burst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

    // Ratio 8, change to 3 mid-period, rejected 1 and 0, stop with pending 6.
    offer(8);
    chk("idle_div8", {16'd0, cur_div}, 32'd8);
    do_start(0, e0);
    push_tick(e0 + 8, 1, 1'b0, 1'b1, 8);
    push_tick(e0 + 16, 2, 1'b0, 1'b1, 3);
    for (int k = 3; k <= 8; k++) push_tick(e0 + 16 + 3 * (k - 2), k, 1'b0, 1'b1, 3);
    eq.push_back(e0 + 27);
    eq.push_back(e0 + 30);
    wait_until(e0 + 11);
    offer(3);
    chk("pend_ready_low", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("pend_div_old", {16'd0, cur_div}, 32'd8);
    wait_until(e0 + 16);
    chk("pend_ready_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
    wait_until(e0 + 26);
    offer(1);
    chk("err1_div", {16'd0, cur_div}, 32'd3);
    wait_until(e0 + 29);
    offer(0);
    chk("err0_div", {16'd0, cur_div}, 32'd3);
    wait_until(e0 + 34);
    offer(6);
    chk("pend6_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    chk("stop2_tick", {31'd0, tick}, 32'd0);
    chk("stop2_done", {31'd0, done}, 32'd0);
    chk("stop2_busy", {31'd0, busy}, 32'd0);
    chk("stop2_div", {16'd0, cur_div}, 32'd6);
    chk("stop2_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

    // start and stop together in IDLE: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk_in);
    chk("ss_busy_late", {31'd0, busy}, 32'd0);
    chk("ss_count", {16'd0, tick_count}, 32'd8);

    // Reset mid-burst with a pending ratio.
    do_start(5, e0);
    push_tick(e0 + 6, 1, 1'b0, 1'b1, 6);
    push_tick(e0 + 12, 2, 1'b0, 1'b1, 6);
    wait_until(e0 + 13);
    offer(9);
    chk("rst2_pend_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    chk("rst2_tick", {31'd0, tick}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_done", {31'd0, done}, 32'd0);
    chk("rst2_count", {16'd0, tick_count}, 32'd0);
    chk("rst2_div", {16'd0, cur_div}, 32'd4);
    chk("rst2_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    repeat (20) @(negedge clk_in);
    chk("rst2_div_late", {16'd0, cur_div}, 32'd4);
    chk("rst2_busy_late", {31'd0, busy}, 32'd0);

    // Every expected event must have been observed.
    chk("tick_queue_left", 32'(tq.size()), 32'd0);
    chk("err_queue_left", 32'(eq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
